// File: rtl/bert_lane_sequencer_pkg.sv
// BERT configuration types shared by the config register block and the lane sequencer.
// Holds the TX/RX config structs, the sequencer state enum and a clock-field compare helper.
package BERTConfig;

    localparam int SEQ_COUNT_W = 16;

    typedef struct packed {
        logic       enable;
        logic       reset;
        logic       clk_from_qpll;
        logic [2:0] clkdiv;
        logic [2:0] prbsmode;
        logic       invert;
        logic [4:0] diffctrl;
        logic [4:0] precursor;
        logic [4:0] postcursor;
    } bert_txconfig_t;

    typedef struct packed {
        logic       enable;
        logic       reset;
        logic       pmareset;
        logic       clk_from_qpll;
        logic [2:0] clkdiv;
        logic [2:0] prbsmode;
        logic       invert;
    } bert_rxconfig_t;

    typedef enum logic [2:0] {
        SEQ_ASSERT,
        SEQ_HOLD,
        SEQ_WAIT_DONE,
        SEQ_READY,
        SEQ_FAULT
    } bert_seq_state_t;

    // Only the clock mux select and divider require the GT to be reset.
    function automatic logic clk_cfg_differs(input logic       qpll_a,
                                             input logic [2:0] div_a,
                                             input logic       qpll_b,
                                             input logic [2:0] div_b);
        return (qpll_a != qpll_b) || (div_a != div_b);
    endfunction

endpackage

// File: rtl/bert_dir_sequencer.sv
// One direction (TX or RX) of the GT reset sequencer: applies clock settings under reset,
// holds the reset for a fixed count, then waits (bounded) for the GT to report reset done.
module bert_dir_sequencer
    import BERTConfig::*;
#(
    parameter int RESET_HOLD_CYCLES   = 32,
    parameter int DONE_TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_updated_i,
    input  logic       cfg_clk_from_qpll_i,
    input  logic [2:0] cfg_clkdiv_i,
    input  logic       sw_reset_i,
    input  logic       resetdone_i,
    output logic       gtreset_o,
    output logic       clk_from_qpll_app_o,
    output logic [2:0] clkdiv_app_o,
    output logic       ready_o,
    output logic       timeout_o
);

    localparam logic [SEQ_COUNT_W-1:0] HOLD_LOAD    = SEQ_COUNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [SEQ_COUNT_W-1:0] TIMEOUT_LOAD = SEQ_COUNT_W'(DONE_TIMEOUT_CYCLES - 1);

    bert_seq_state_t        state_q, state_d;
    logic [SEQ_COUNT_W-1:0] count_q, count_d;
    logic                   qpll_app_q, qpll_app_d;
    logic [2:0]             clkdiv_app_q, clkdiv_app_d;
    logic                   trigger;

    assign trigger = cfg_updated_i &&
                     clk_cfg_differs(cfg_clk_from_qpll_i, cfg_clkdiv_i, qpll_app_q, clkdiv_app_q);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= SEQ_ASSERT;
            count_q      <= HOLD_LOAD;
            qpll_app_q   <= 1'b0;
            clkdiv_app_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            qpll_app_q   <= qpll_app_d;
            clkdiv_app_q <= clkdiv_app_d;
        end
    end

    // The counter serves both as the hold count and as the resetdone timeout.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        qpll_app_d   = qpll_app_q;
        clkdiv_app_d = clkdiv_app_q;
        if (trigger) begin
            state_d      = SEQ_ASSERT;
            count_d      = HOLD_LOAD;
            qpll_app_d   = cfg_clk_from_qpll_i;
            clkdiv_app_d = cfg_clkdiv_i;
        end else begin
            case (state_q)
                SEQ_ASSERT: begin
                    state_d      = SEQ_HOLD;
                    count_d      = HOLD_LOAD;
                    qpll_app_d   = cfg_clk_from_qpll_i;
                    clkdiv_app_d = cfg_clkdiv_i;
                end
                SEQ_HOLD: begin
                    if (sw_reset_i) begin
                        count_d = HOLD_LOAD;
                    end else if (count_q == '0) begin
                        state_d = SEQ_WAIT_DONE;
                        count_d = TIMEOUT_LOAD;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                SEQ_WAIT_DONE: begin
                    if (sw_reset_i) begin
                        state_d = SEQ_HOLD;
                        count_d = HOLD_LOAD;
                    end else if (resetdone_i) begin
                        state_d = SEQ_READY;
                    end else if (count_q == '0) begin
                        state_d = SEQ_FAULT;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                SEQ_READY, SEQ_FAULT: begin
                    if (sw_reset_i) begin
                        state_d = SEQ_HOLD;
                        count_d = HOLD_LOAD;
                    end
                end
                default: begin
                    state_d = SEQ_ASSERT;
                    count_d = HOLD_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        gtreset_o           = (state_q == SEQ_ASSERT) || (state_q == SEQ_HOLD);
        ready_o             = (state_q == SEQ_READY);
        timeout_o           = (state_q == SEQ_FAULT);
        clk_from_qpll_app_o = qpll_app_q;
        clkdiv_app_o        = clkdiv_app_q;
    end

endmodule

// File: rtl/bert_lane_sequencer.sv
// BERT lane reset sequencer: independent TX and RX GT reset sequencing driven by
// clock-setting changes in the config registers, plus a registered RX PMA reset.
module bert_lane_sequencer
    import BERTConfig::*;
#(
    parameter int RESET_HOLD_CYCLES   = 32,
    parameter int DONE_TIMEOUT_CYCLES = 65535
) (
    input  logic           pclk,
    input  logic           preset_n,
    input  bert_txconfig_t tx_config,
    input  bert_rxconfig_t rx_config,
    input  logic           config_updated,
    input  logic           tx_resetdone,
    input  logic           rx_resetdone,
    output logic           tx_gtreset,
    output logic           rx_gtreset,
    output logic           rx_pmareset,
    output logic           tx_clk_from_qpll_app,
    output logic           rx_clk_from_qpll_app,
    output logic [2:0]     tx_clkdiv_app,
    output logic [2:0]     rx_clkdiv_app,
    output logic           tx_ready,
    output logic           rx_ready,
    output logic           tx_timeout,
    output logic           rx_timeout
);

    logic rx_pmareset_q;
    logic unused_cfg;

    // Pattern, polarity and driver fields belong to other blocks and never reset the GT.
    assign unused_cfg = ^{tx_config.enable, tx_config.prbsmode, tx_config.invert,
                          tx_config.diffctrl, tx_config.precursor, tx_config.postcursor,
                          rx_config.enable, rx_config.prbsmode, rx_config.invert};

    bert_dir_sequencer #(
        .RESET_HOLD_CYCLES  (RESET_HOLD_CYCLES),
        .DONE_TIMEOUT_CYCLES(DONE_TIMEOUT_CYCLES)
    ) u_tx_seq (
        .clk_i              (pclk),
        .rst_n_i            (preset_n),
        .cfg_updated_i      (config_updated),
        .cfg_clk_from_qpll_i(tx_config.clk_from_qpll),
        .cfg_clkdiv_i       (tx_config.clkdiv),
        .sw_reset_i         (tx_config.reset),
        .resetdone_i        (tx_resetdone),
        .gtreset_o          (tx_gtreset),
        .clk_from_qpll_app_o(tx_clk_from_qpll_app),
        .clkdiv_app_o       (tx_clkdiv_app),
        .ready_o            (tx_ready),
        .timeout_o          (tx_timeout)
    );

    bert_dir_sequencer #(
        .RESET_HOLD_CYCLES  (RESET_HOLD_CYCLES),
        .DONE_TIMEOUT_CYCLES(DONE_TIMEOUT_CYCLES)
    ) u_rx_seq (
        .clk_i              (pclk),
        .rst_n_i            (preset_n),
        .cfg_updated_i      (config_updated),
        .cfg_clk_from_qpll_i(rx_config.clk_from_qpll),
        .cfg_clkdiv_i       (rx_config.clkdiv),
        .sw_reset_i         (rx_config.reset),
        .resetdone_i        (rx_resetdone),
        .gtreset_o          (rx_gtreset),
        .clk_from_qpll_app_o(rx_clk_from_qpll_app),
        .clkdiv_app_o       (rx_clkdiv_app),
        .ready_o            (rx_ready),
        .timeout_o          (rx_timeout)
    );

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            rx_pmareset_q <= 1'b0;
        end else begin
            rx_pmareset_q <= rx_config.pmareset;
        end
    end

    assign rx_pmareset = rx_pmareset_q;

endmodule

// File: tb/tb_bert_lane_sequencer.sv
// Directed bench for bert_lane_sequencer: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled on the falling edge.
module tb_bert_lane_sequencer;
    import BERTConfig::*;

    localparam int HOLD    = 32;
    localparam int TIMEOUT = 100;
    localparam int LIMIT   = 400;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    logic           pclk;
    logic           preset_n;
    bert_txconfig_t tx_config;
    bert_rxconfig_t rx_config;
    logic           config_updated;
    logic           tx_resetdone, rx_resetdone;
    logic           tx_gtreset, rx_gtreset, rx_pmareset;
    logic           tx_clk_from_qpll_app, rx_clk_from_qpll_app;
    logic [2:0]     tx_clkdiv_app, rx_clkdiv_app;
    logic           tx_ready, rx_ready, tx_timeout, rx_timeout;

    expect_t        sbQ[$];
    int             testsRun  = 0;
    int             failCount = 0;

    bert_lane_sequencer #(
        .RESET_HOLD_CYCLES  (HOLD),
        .DONE_TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .pclk                (pclk),
        .preset_n            (preset_n),
        .tx_config           (tx_config),
        .rx_config           (rx_config),
        .config_updated      (config_updated),
        .tx_resetdone        (tx_resetdone),
        .rx_resetdone        (rx_resetdone),
        .tx_gtreset          (tx_gtreset),
        .rx_gtreset          (rx_gtreset),
        .rx_pmareset         (rx_pmareset),
        .tx_clk_from_qpll_app(tx_clk_from_qpll_app),
        .rx_clk_from_qpll_app(rx_clk_from_qpll_app),
        .tx_clkdiv_app       (tx_clkdiv_app),
        .rx_clkdiv_app       (rx_clkdiv_app),
        .tx_ready            (tx_ready),
        .rx_ready            (rx_ready),
        .tx_timeout          (tx_timeout),
        .rx_timeout          (rx_timeout)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic expectValue(input string tag, input int v);
        expect_t e;
        e.tag   = tag;
        e.value = 32'(v);
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        testsRun++;
        if (sbQ.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
        end else begin
            e = sbQ.pop_front();
            assert (observed === e.value) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
            end
        end
    endtask

    // Drives a config write at a falling edge; returns one edge later with the strobe low.
    task automatic applyStimulus(input bert_txconfig_t t, input bert_rxconfig_t r, input bit upd);
        tx_config      = t;
        rx_config      = r;
        config_updated = upd;
        tick(1);
        config_updated = 1'b0;
    endtask

    task automatic countGtresetHigh(input bit isTx, output int n);
        n = 0;
        while (((isTx ? tx_gtreset : rx_gtreset) === 1'b1) && n < LIMIT) begin
            n++;
            tick(1);
        end
    endtask

    task automatic waitReady(input bit isTx, output int n);
        n = 0;
        while (((isTx ? tx_ready : rx_ready) !== 1'b1) && n < LIMIT) begin
            n++;
            tick(1);
        end
    endtask

    task automatic waitRxTimeout(output int n);
        n = 0;
        while ((rx_timeout !== 1'b1) && n < LIMIT) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        bert_txconfig_t t;
        bert_rxconfig_t r;
        int n;
        int seen;

        t = '0;
        r = '0;
        r.clkdiv = 3'd2;
        preset_n       = 1'b0;
        tx_config      = t;
        rx_config      = r;
        config_updated = 1'b0;
        tx_resetdone   = 1'b1;
        rx_resetdone   = 1'b1;
        tick(3);

        expectValue("reset_tx_gtreset", 1);    checkOutput(32'(tx_gtreset));
        expectValue("reset_rx_gtreset", 1);    checkOutput(32'(rx_gtreset));
        expectValue("reset_rx_pmareset", 0);   checkOutput(32'(rx_pmareset));
        expectValue("reset_rx_clkdiv_app", 0); checkOutput(32'(rx_clkdiv_app));
        expectValue("reset_tx_ready", 0);      checkOutput(32'(tx_ready));
        expectValue("reset_rx_timeout", 0);    checkOutput(32'(rx_timeout));

        // Power-up: ASSERT plus a full hold, then ready one cycle after WAIT_DONE.
        preset_n = 1'b1;
        expectValue("powerup_gtreset_cycles", 1 + HOLD);
        countGtresetHigh(1'b1, n);
        checkOutput(32'(n));
        expectValue("powerup_ready_latency", 1);
        waitReady(1'b1, n);
        checkOutput(32'(n));
        expectValue("powerup_rx_clkdiv_app", 2); checkOutput(32'(rx_clkdiv_app));
        expectValue("powerup_rx_ready", 1);      checkOutput(32'(rx_ready));

        // Clock change on TX only.
        expectValue("clk_pre_tx_clkdiv_app", 0); checkOutput(32'(tx_clkdiv_app));
        t.clkdiv = 3'd3;
        expectValue("clk_tx_gtreset", 1);      expectValue("clk_tx_clkdiv_app", 3);
        expectValue("clk_rx_gtreset", 0);      expectValue("clk_rx_ready", 1);
        expectValue("clk_rx_clkdiv_app", 2);
        applyStimulus(t, r, 1'b1);
        checkOutput(32'(tx_gtreset));  checkOutput(32'(tx_clkdiv_app));
        checkOutput(32'(rx_gtreset));  checkOutput(32'(rx_ready));
        checkOutput(32'(rx_clkdiv_app));
        expectValue("clk_gtreset_cycles", 1 + HOLD);
        countGtresetHigh(1'b1, n);
        checkOutput(32'(n));
        expectValue("clk_ready_latency", 1);
        waitReady(1'b1, n);
        checkOutput(32'(n));

        // Pattern-only write must not disturb the lane.
        t.prbsmode = t.prbsmode ^ 3'b101;
        expectValue("prbs_gtreset_seen", 0);
        expectValue("prbs_ready_drop_seen", 0);
        applyStimulus(t, r, 1'b1);
        seen = 0;
        n    = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_gtreset !== 1'b0) seen++;
            if (tx_ready !== 1'b1) n++;
            tick(1);
        end
        checkOutput(32'(seen));
        checkOutput(32'(n));

        // Retrigger at hold count 10: the second value applies and the hold restarts.
        t.clkdiv = 3'd5;
        applyStimulus(t, r, 1'b1);
        tick(22);
        expectValue("retrig_mid_clkdiv_app", 5); checkOutput(32'(tx_clkdiv_app));
        expectValue("retrig_mid_gtreset", 1);    checkOutput(32'(tx_gtreset));
        t.clkdiv = 3'd6;
        expectValue("retrig_clkdiv_app", 6);
        applyStimulus(t, r, 1'b1);
        checkOutput(32'(tx_clkdiv_app));
        expectValue("retrig_gtreset_cycles", 1 + HOLD);
        countGtresetHigh(1'b1, n);
        checkOutput(32'(n));
        expectValue("retrig_ready_latency", 1);
        waitReady(1'b1, n);
        checkOutput(32'(n));

        // Software reset held for 200 cycles, then a full hold after release.
        t.reset = 1'b1;
        expectValue("swrst_ready", 0);
        applyStimulus(t, r, 1'b1);
        checkOutput(32'(tx_ready));
        expectValue("swrst_gtreset_low_seen", 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_gtreset !== 1'b1) seen++;
            tick(1);
        end
        checkOutput(32'(seen));
        t.reset   = 1'b0;
        tx_config = t;
        expectValue("swrst_release_cycles", HOLD);
        countGtresetHigh(1'b1, n);
        checkOutput(32'(n));
        expectValue("swrst_ready_latency", 1);
        waitReady(1'b1, n);
        checkOutput(32'(n));

        // RX timeout with resetdone held low.
        rx_resetdone = 1'b0;
        r.clkdiv = 3'd1;
        expectValue("to_rx_clkdiv_app", 1);
        expectValue("to_rx_timeout_start", 0);
        applyStimulus(t, r, 1'b1);
        checkOutput(32'(rx_clkdiv_app));
        checkOutput(32'(rx_timeout));
        expectValue("to_gtreset_cycles", 1 + HOLD);
        countGtresetHigh(1'b0, n);
        checkOutput(32'(n));
        expectValue("to_wait_cycles", TIMEOUT);
        waitRxTimeout(n);
        checkOutput(32'(n));
        expectValue("to_rx_ready", 0);   checkOutput(32'(rx_ready));
        expectValue("to_rx_gtreset", 0); checkOutput(32'(rx_gtreset));
        expectValue("to_tx_ready", 1);   checkOutput(32'(tx_ready));
        rx_resetdone = 1'b1;
        tick(3);
        expectValue("to_fault_sticky", 1); checkOutput(32'(rx_timeout));
        r.clkdiv = 3'd4;
        expectValue("to_clear_timeout", 0);
        expectValue("to_clear_gtreset", 1);
        expectValue("to_clear_clkdiv_app", 4);
        applyStimulus(t, r, 1'b1);
        checkOutput(32'(rx_timeout));
        checkOutput(32'(rx_gtreset));
        checkOutput(32'(rx_clkdiv_app));
        expectValue("to_recover_cycles", 1 + HOLD);
        countGtresetHigh(1'b0, n);
        checkOutput(32'(n));
        expectValue("to_recover_ready_latency", 1);
        waitReady(1'b0, n);
        checkOutput(32'(n));

        // PMA reset is a plain one-cycle register.
        r.pmareset = 1'b1;
        rx_config  = r;
        expectValue("pma_before_edge", 0); checkOutput(32'(rx_pmareset));
        tick(1);
        expectValue("pma_set", 1);         checkOutput(32'(rx_pmareset));
        expectValue("pma_no_gtreset", 0);  checkOutput(32'(rx_gtreset));
        r.pmareset = 1'b0;
        rx_config  = r;
        tick(1);
        expectValue("pma_clear", 0);       checkOutput(32'(rx_pmareset));

        // Reset mid-hold aborts, then release runs a fresh power-up sequence.
        t.clkdiv = 3'd7;
        applyStimulus(t, r, 1'b1);
        tick(5);
        preset_n = 1'b0;
        tick(1);
        expectValue("midrst_tx_gtreset", 1);    checkOutput(32'(tx_gtreset));
        expectValue("midrst_tx_clkdiv_app", 0); checkOutput(32'(tx_clkdiv_app));
        expectValue("midrst_rx_clkdiv_app", 0); checkOutput(32'(rx_clkdiv_app));
        expectValue("midrst_rx_ready", 0);      checkOutput(32'(rx_ready));
        tick(2);
        preset_n = 1'b1;
        expectValue("midrst_gtreset_cycles", 1 + HOLD);
        countGtresetHigh(1'b1, n);
        checkOutput(32'(n));
        expectValue("midrst_ready_latency", 1);
        waitReady(1'b1, n);
        checkOutput(32'(n));
        expectValue("midrst_tx_clkdiv_final", 7); checkOutput(32'(tx_clkdiv_app));
        expectValue("midrst_rx_clkdiv_final", 4); checkOutput(32'(rx_clkdiv_app));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
